// File: rtl/song_pkg.sv
// Shared types and constants for the song recorder: note codes, entry layout, FSM states.
package song_pkg;

  localparam int NOTE_W = 4;

  // Note codes as produced by the keyboard decode; 0 means no key held.
  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C    = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;

  // One song entry is {note, duration}.
  function automatic int entry_width(input int dur_w);
    return NOTE_W + dur_w;
  endfunction

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMMIT  = 3'd3,
    S_TERM    = 3'd4
  } song_state_e;

endpackage

// File: rtl/note_stabilizer.sv
// Synchronises the live note code and accepts a new value only after it has been
// sampled unchanged STABLE_CYC times; emits a one-cycle pulse when note_q changes.
module note_stabilizer import song_pkg::*; #(
  parameter int STABLE_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] note_in,
  output logic [NOTE_W-1:0] note_q,
  output logic              change
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC);

  logic [NOTE_W-1:0] sync1;
  logic [NOTE_W-1:0] sync2;
  logic [NOTE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;

  // Two-flop synchroniser for the asynchronous key code.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= note_in;
      sync2 <= sync1;
    end
  end

  // Track the candidate value and how many consecutive samples it has held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cand <= '0;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= CNT_W'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Promote a candidate that has held long enough and differs from the accepted note.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_q <= '0;
      change <= 1'b0;
    end else begin
      change <= 1'b0;
      if ((cnt == CNT_MAX) && (cand != note_q)) begin
        note_q <= cand;
        change <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/song_recorder.sv
// Records live keyboard play into song RAM as {note, duration} entries followed by a
// {0,0} terminator. Write handshake: wr_en with wr_addr/wr_note/wr_dur is held stable
// until a rising clk edge where wr_en && wr_ready, which is the single accepted write.
module song_recorder import song_pkg::*; #(
  parameter int ADDR_W     = 5,
  parameter int DUR_W      = 16,
  parameter int TICK_DIV   = 100000,
  parameter int STABLE_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_en,
  input  logic [NOTE_W-1:0] note_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [NOTE_W-1:0] wr_note,
  output logic [DUR_W-1:0]  wr_dur,
  output logic              recording,
  output logic              full,
  output logic              done,
  output logic [ADDR_W-1:0] song_len,
  output song_state_e       fsm_state
);

  localparam int ENTRY_W = entry_width(DUR_W);
  localparam int PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]  PRE_MAX     = PRE_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0]  DUR_MAX     = {DUR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_LAST   = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_PENULT = {{(ADDR_W-1){1'b1}}, 1'b0};

  song_state_e         state;
  song_state_e         next_state;
  logic [NOTE_W-1:0]   note_q;
  logic                change;
  logic [PRE_W-1:0]    pre_cnt;
  logic                tick;
  logic [DUR_W-1:0]    dur_cnt;
  logic [NOTE_W-1:0]   cur_note;
  logic [ENTRY_W-1:0]  hold_entry;
  logic                stop_pending;
  logic                rec_s1;
  logic                rec_s2;
  logic                rec_d;
  logic                rec_rise;
  logic                rec_fall;
  logic                stop_commit;
  logic                arm_start;
  logic                run_change;
  logic                write_accept;

  note_stabilizer #(.STABLE_CYC(STABLE_CYC)) u_stab (
    .clk     (clk),
    .reset   (reset),
    .note_in (note_in),
    .note_q  (note_q),
    .change  (change)
  );

  assign rec_rise     = rec_s2 & ~rec_d;
  assign rec_fall     = ~rec_s2 & rec_d;
  assign tick         = (pre_cnt == PRE_MAX);
  // On stop, only a real note with measurable length is worth an entry.
  assign stop_commit  = (cur_note != NOTE_REST) && (dur_cnt != '0);
  assign arm_start    = (state == S_ARM) && !rec_fall && (note_q != NOTE_REST);
  assign run_change   = (state == S_CAPTURE) && !rec_fall && change;
  assign write_accept = wr_en && wr_ready;
  assign fsm_state    = state;

  // Synchronise rec_en and keep the previous level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_s1 <= 1'b0;
      rec_s2 <= 1'b0;
      rec_d  <= 1'b0;
    end else begin
      rec_s1 <= rec_en;
      rec_s2 <= rec_s1;
      rec_d  <= rec_s2;
    end
  end

  // Free-running prescaler producing one duration tick every TICK_DIV cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Run length counter; a restart keeps the tick of the restart cycle so no time is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dur_cnt <= '0;
    end else if (arm_start || run_change) begin
      dur_cnt <= tick ? DUR_W'(1) : '0;
    end else if (tick && (dur_cnt != DUR_MAX)) begin
      dur_cnt <= dur_cnt + DUR_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else state <= next_state;
  end

  // FSM next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: begin
        if (rec_rise) next_state = S_ARM;
      end
      S_ARM: begin
        if (rec_fall) next_state = S_TERM;
        else if (note_q != NOTE_REST) next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (rec_fall) next_state = stop_commit ? S_COMMIT : S_TERM;
        else if (change && (dur_cnt != '0)) next_state = S_COMMIT;
      end
      S_COMMIT: begin
        if (wr_ready) begin
          if (stop_pending || rec_fall || (wr_addr == ADDR_PENULT)) next_state = S_TERM;
          else next_state = S_CAPTURE;
        end
      end
      S_TERM: begin
        if (wr_ready) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs: write request and data presented to the song RAM.
  always_comb begin
    wr_en     = 1'b0;
    recording = 1'b0;
    wr_note   = hold_entry[ENTRY_W-1 -: NOTE_W];
    wr_dur    = hold_entry[DUR_W-1:0];
    unique case (state)
      S_ARM, S_CAPTURE: recording = 1'b1;
      S_COMMIT: begin
        recording = 1'b1;
        wr_en     = 1'b1;
      end
      S_TERM: begin
        wr_en   = 1'b1;
        wr_note = NOTE_REST;
        wr_dur  = '0;
      end
      default: begin
        wr_en     = 1'b0;
        recording = 1'b0;
      end
    endcase
  end

  // Entry capture, address/length bookkeeping and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_note     <= '0;
      hold_entry   <= '0;
      stop_pending <= 1'b0;
      wr_addr      <= '0;
      song_len     <= '0;
      full         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == S_TERM) && wr_ready;
      unique case (state)
        S_IDLE: begin
          if (rec_rise) begin
            wr_addr      <= '0;
            song_len     <= '0;
            full         <= 1'b0;
            stop_pending <= 1'b0;
          end
        end
        S_ARM: begin
          if (arm_start) cur_note <= note_q;
        end
        S_CAPTURE: begin
          if (rec_fall) begin
            if (stop_commit) begin
              hold_entry   <= {cur_note, dur_cnt};
              stop_pending <= 1'b1;
            end
          end else if (change) begin
            cur_note <= note_q;
            if (dur_cnt != '0) hold_entry <= {cur_note, dur_cnt};
          end
        end
        S_COMMIT: begin
          if (rec_fall) stop_pending <= 1'b1;
          if (write_accept) begin
            wr_addr <= wr_addr + ADDR_W'(1);
            if (song_len != ADDR_LAST) song_len <= song_len + ADDR_W'(1);
            if (wr_addr == ADDR_PENULT) full <= 1'b1;
          end
        end
        S_TERM: begin
          if (write_accept) stop_pending <= 1'b0;
        end
        default: begin
          stop_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder with small timing parameters.
module tb_song_recorder;
  import song_pkg::*;

  localparam int AW = 3;
  localparam int DW = 16;
  localparam int EW = AW + 4 + DW;

  logic              clk = 1'b0;
  logic              reset;
  logic              rec_en;
  logic [3:0]        note_in;
  logic              wr_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [3:0]        wr_note;
  logic [DW-1:0]     wr_dur;
  logic              recording;
  logic              full;
  logic              done;
  logic [AW-1:0]     song_len;
  song_state_e       fsm_state;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int done_base;
  logic [EW-1:0] obs_q[$];
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] tmp;

  song_recorder #(.ADDR_W(AW), .DUR_W(DW), .TICK_DIV(4), .STABLE_CYC(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .rec_en    (rec_en),
    .note_in   (note_in),
    .wr_ready  (wr_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_note   (wr_note),
    .wr_dur    (wr_dur),
    .recording (recording),
    .full      (full),
    .done      (done),
    .song_len  (song_len),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: log writes that will be accepted at the next edge, count done pulses.
  always @(negedge clk) begin
    if (reset && wr_en && wr_ready) obs_q.push_back({wr_addr, wr_note, wr_dur});
    if (done) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [3:0] n, input logic [DW-1:0] d);
    exp_q.push_back({a, n, d});
  endtask

  task automatic drain(input string tag);
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else o = '1;
      check({tag, "_entry"}, 32'(o), 32'(e));
    end
    obs_q.delete();
  endtask

  task automatic wait_done(input string tag, input int base, input int budget);
    int k;
    k = 0;
    while ((done_cnt == base) && (k < budget)) begin
      cyc(1);
      k++;
    end
    cyc(3);
    check({tag, "_done_once"}, 32'(done_cnt - base), 32'd1);
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int k;
    k = 0;
    while (!wr_en && (k < budget)) begin
      cyc(1);
      k++;
    end
    check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
  endtask

  initial begin
    reset    = 1'b0;
    rec_en   = 1'b0;
    note_in  = 4'd0;
    wr_ready = 1'b1;
    cyc(3);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_note", 32'(wr_note), 32'd0);
    check("rst_wr_dur", 32'(wr_dur), 32'd0);
    check("rst_recording", 32'(recording), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_song_len", 32'(song_len), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(S_IDLE));
    reset = 1'b1;
    cyc(5);

    // Leading rest dropped, single note, trailing rest dropped.
    rec_en = 1'b1;
    cyc(5);
    check("t1_arm_state", 32'(fsm_state), 32'(S_ARM));
    check("t1_recording", 32'(recording), 32'd1);
    cyc(35);
    check("t1_still_arm", 32'(fsm_state), 32'(S_ARM));
    note_in = 4'd5;
    cyc(40);
    note_in = 4'd0;
    cyc(20);
    check("t1_capture", 32'(fsm_state), 32'(S_CAPTURE));
    check("t1_len_mid", 32'(song_len), 32'd1);
    done_base = done_cnt;
    rec_en = 1'b0;
    wait_done("t1", done_base, 30);
    push_exp(3'd0, 4'd5, 16'd10);
    push_exp(3'd1, 4'd0, 16'd0);
    drain("t1");
    check("t1_len", 32'(song_len), 32'd1);
    check("t1_full", 32'(full), 32'd0);
    check("t1_idle", 32'(fsm_state), 32'(S_IDLE));
    check("t1_rec_off", 32'(recording), 32'd0);

    // Note, recorded rest, note.
    rec_en = 1'b1;
    cyc(10);
    note_in = 4'd3;
    cyc(20);
    note_in = 4'd0;
    cyc(12);
    note_in = 4'd7;
    cyc(20);
    note_in = 4'd0;
    cyc(20);
    done_base = done_cnt;
    rec_en = 1'b0;
    wait_done("t2", done_base, 30);
    push_exp(3'd0, 4'd3, 16'd5);
    push_exp(3'd1, 4'd0, 16'd3);
    push_exp(3'd2, 4'd7, 16'd5);
    push_exp(3'd3, 4'd0, 16'd0);
    drain("t2");
    check("t2_len", 32'(song_len), 32'd3);

    // Back-pressure: request and data held while wr_ready is low.
    rec_en = 1'b1;
    cyc(10);
    note_in = 4'd6;
    cyc(40);
    wr_ready = 1'b0;
    note_in = 4'd0;
    wait_wr("t3", 20);
    for (int i = 0; i < 10; i++) begin
      check("t3_hold", 32'({wr_en, wr_addr, wr_note, wr_dur}), 32'({1'b1, 3'd0, 4'd6, 16'd10}));
      check("t3_no_write", 32'(obs_q.size()), 32'd0);
      cyc(1);
    end
    wr_ready = 1'b1;
    cyc(3);
    check("t3_back_capture", 32'(fsm_state), 32'(S_CAPTURE));
    check("t3_len_mid", 32'(song_len), 32'd1);
    cyc(10);
    done_base = done_cnt;
    rec_en = 1'b0;
    wait_done("t3", done_base, 30);
    push_exp(3'd0, 4'd6, 16'd10);
    push_exp(3'd1, 4'd0, 16'd0);
    drain("t3");

    // Stop while a note is still held: the run is committed before the terminator.
    rec_en = 1'b1;
    cyc(10);
    note_in = 4'd2;
    cyc(40);
    done_base = done_cnt;
    rec_en = 1'b0;
    wait_done("t4", done_base, 30);
    check("t4_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() > 0) tmp = obs_q.pop_front();
    else tmp = '1;
    check("t4_addr_note", 32'(tmp[EW-1:DW]), 32'({3'd0, 4'd2}));
    check("t4_dur_range", 32'((tmp[DW-1:0] >= 16'd9) && (tmp[DW-1:0] <= 16'd10)), 32'd1);
    push_exp(3'd1, 4'd0, 16'd0);
    drain("t4");
    check("t4_len", 32'(song_len), 32'd1);
    note_in = 4'd0;
    cyc(10);

    // Short glitch inside a held note is filtered.
    rec_en = 1'b1;
    cyc(10);
    note_in = 4'd4;
    cyc(20);
    note_in = 4'd9;
    cyc(1);
    note_in = 4'd4;
    cyc(19);
    note_in = 4'd0;
    cyc(20);
    done_base = done_cnt;
    rec_en = 1'b0;
    wait_done("t5", done_base, 30);
    push_exp(3'd0, 4'd4, 16'd10);
    push_exp(3'd1, 4'd0, 16'd0);
    drain("t5");

    // Capacity: 8 alternating notes fill the store.
    rec_en = 1'b1;
    cyc(10);
    check("t6_full_clear", 32'(full), 32'd0);
    done_base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      note_in = (i % 2 == 0) ? 4'd1 : 4'd2;
      cyc(8);
    end
    wait_done("t6", done_base, 30);
    for (int i = 0; i < 7; i++) push_exp(3'(i), (i % 2 == 0) ? 4'd1 : 4'd2, 16'd2);
    push_exp(3'd7, 4'd0, 16'd0);
    drain("t6");
    check("t6_full", 32'(full), 32'd1);
    check("t6_len", 32'(song_len), 32'd7);
    check("t6_idle", 32'(fsm_state), 32'(S_IDLE));
    note_in = 4'd5;
    cyc(10);
    note_in = 4'd0;
    cyc(10);
    check("t6_ignored", 32'(obs_q.size()), 32'd0);
    check("t6_full_sticky", 32'(full), 32'd1);
    check("t6_len_kept", 32'(song_len), 32'd7);
    rec_en = 1'b0;
    cyc(5);

    // Asynchronous reset in the middle of a stalled write.
    rec_en = 1'b1;
    cyc(10);
    note_in = 4'd3;
    cyc(20);
    note_in = 4'd0;
    cyc(20);
    wr_ready = 1'b0;
    note_in = 4'd6;
    wait_wr("t7", 20);
    check("t7_len_before", 32'(song_len), 32'd1);
    done_base = done_cnt;
    #1;
    reset = 1'b0;
    #1;
    check("t7_wr_en", 32'(wr_en), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_full", 32'(full), 32'd0);
    check("t7_len", 32'(song_len), 32'd0);
    check("t7_state", 32'(fsm_state), 32'(S_IDLE));
    check("t7_recording", 32'(recording), 32'd0);
    rec_en = 1'b0;
    note_in = 4'd0;
    cyc(3);
    reset = 1'b1;
    wr_ready = 1'b1;
    cyc(20);
    push_exp(3'd0, 4'd3, 16'd5);
    drain("t7");
    check("t7_no_done", 32'(done_cnt - done_base), 32'd0);
    check("t7_idle_after", 32'(fsm_state), 32'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
